// File: rtl/ex_div.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ex_div
// Description : Execute stage. Handles single-cycle logic, shift and HI/LO
//               moves, and runs DIV/DIVU on an iterative restoring divider
//               that needs DATA_W cycles. The pipeline is held through
//               stallreq_o while the divider runs.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_div #(
    parameter int DATA_W   = 32,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int RADDR_W  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ALUOP_W-1:0]  aluop_i,
    input  logic [ALUSEL_W-1:0] alusel_i,
    input  logic [DATA_W-1:0]   reg1_i,
    input  logic [DATA_W-1:0]   reg2_i,
    input  logic [RADDR_W-1:0]  wd_i,
    input  logic                wreg_i,
    input  logic [DATA_W-1:0]   hi_i,
    input  logic [DATA_W-1:0]   lo_i,
    input  logic                flush_i,
    output logic [RADDR_W-1:0]  wd_o,
    output logic                wreg_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic                whilo_o,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o,
    output logic                stallreq_o
);

    localparam logic [ALUOP_W-1:0] OP_AND  = ALUOP_W'(8'b0010_0100);
    localparam logic [ALUOP_W-1:0] OP_OR   = ALUOP_W'(8'b0010_0101);
    localparam logic [ALUOP_W-1:0] OP_XOR  = ALUOP_W'(8'b0010_0110);
    localparam logic [ALUOP_W-1:0] OP_NOR  = ALUOP_W'(8'b0010_0111);
    localparam logic [ALUOP_W-1:0] OP_SLL  = ALUOP_W'(8'b0111_1100);
    localparam logic [ALUOP_W-1:0] OP_SRL  = ALUOP_W'(8'b0000_0010);
    localparam logic [ALUOP_W-1:0] OP_SRA  = ALUOP_W'(8'b0000_0011);
    localparam logic [ALUOP_W-1:0] OP_MFHI = ALUOP_W'(8'b0001_0000);
    localparam logic [ALUOP_W-1:0] OP_MTHI = ALUOP_W'(8'b0001_0001);
    localparam logic [ALUOP_W-1:0] OP_MFLO = ALUOP_W'(8'b0001_0010);
    localparam logic [ALUOP_W-1:0] OP_MTLO = ALUOP_W'(8'b0001_0011);
    localparam logic [ALUOP_W-1:0] OP_DIV  = ALUOP_W'(8'b0001_1010);
    localparam logic [ALUOP_W-1:0] OP_DIVU = ALUOP_W'(8'b0001_1011);

    localparam logic [ALUSEL_W-1:0] SEL_LOGIC = ALUSEL_W'(3'b001);
    localparam logic [ALUSEL_W-1:0] SEL_SHIFT = ALUSEL_W'(3'b010);
    localparam logic [ALUSEL_W-1:0] SEL_MOVE  = ALUSEL_W'(3'b011);

    localparam int               SH_W     = $clog2(DATA_W);
    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   dend_q, dend_d;   // dividend magnitude, shifts into quotient
    logic [DATA_W-1:0]   dsor_q, dsor_d;   // divisor magnitude
    logic [DATA_W-1:0]   rem_q, rem_d;     // partial remainder
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;

    logic [SH_W-1:0]     shamt;
    logic [DATA_W-1:0]   logic_res, shift_res, move_res, alu_res;
    logic                is_div, is_signed;
    logic [DATA_W:0]     rem_shift;
    logic [DATA_W-1:0]   rem_trial;
    logic                step_ge;
    logic                div_stall, div_done;

    assign shamt     = reg1_i[SH_W-1:0];
    assign is_div    = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign is_signed = (aluop_i == OP_DIV);

    // Single-cycle result classes and the alusel-driven result mux
    always_comb begin
        logic_res = '0;
        shift_res = '0;
        move_res  = '0;
        alu_res   = '0;
        case (aluop_i)
            OP_AND:  logic_res = reg1_i & reg2_i;
            OP_OR:   logic_res = reg1_i | reg2_i;
            OP_XOR:  logic_res = reg1_i ^ reg2_i;
            OP_NOR:  logic_res = ~(reg1_i | reg2_i);
            default: logic_res = '0;
        endcase
        case (aluop_i)
            OP_SLL:  shift_res = reg2_i << shamt;
            OP_SRL:  shift_res = reg2_i >> shamt;
            OP_SRA:  shift_res = $signed(reg2_i) >>> shamt;
            default: shift_res = '0;
        endcase
        case (aluop_i)
            OP_MFHI: move_res = hi_i;
            OP_MFLO: move_res = lo_i;
            default: move_res = '0;
        endcase
        case (alusel_i)
            SEL_LOGIC: alu_res = logic_res;
            SEL_SHIFT: alu_res = shift_res;
            SEL_MOVE:  alu_res = move_res;
            default:   alu_res = '0;
        endcase
    end

    // Divider next-state: latch magnitudes, run one restoring step per cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dend_d    = dend_q;
        dsor_d    = dsor_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div_stall = 1'b0;
        div_done  = 1'b0;

        // The shifted remainder can be one bit wider than the divisor; the
        // difference is always below the divisor when the step succeeds.
        rem_shift = {rem_q, dend_q[DATA_W-1]};
        step_ge   = (rem_shift >= {1'b0, dsor_q});
        rem_trial = rem_shift[DATA_W-1:0] - dsor_q;

        case (state_q)
            S_IDLE: begin
                if (is_div) begin
                    div_stall = 1'b1;
                    if (reg2_i == '0) begin
                        dend_d    = '0;
                        rem_d     = '0;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = S_DONE;
                    end else begin
                        dend_d    = (is_signed && reg1_i[DATA_W-1]) ? -reg1_i : reg1_i;
                        dsor_d    = (is_signed && reg2_i[DATA_W-1]) ? -reg2_i : reg2_i;
                        rem_d     = '0;
                        cnt_d     = '0;
                        neg_quo_d = is_signed && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
                        neg_rem_d = is_signed && reg1_i[DATA_W-1];
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                div_stall = 1'b1;
                rem_d     = step_ge ? rem_trial : rem_shift[DATA_W-1:0];
                dend_d    = {dend_q[DATA_W-2:0], step_ge};
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                div_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // An annulled instruction must never stall or write HI/LO
        if (flush_i) begin
            state_d   = S_IDLE;
            div_stall = 1'b0;
            div_done  = 1'b0;
        end
    end

    // Divider state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dend_q    <= '0;
            dsor_q    <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dend_q    <= dend_d;
            dsor_q    <= dsor_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    // Output assembly: pass-through, HI/LO writes, flush and reset masking
    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i && !flush_i;
        wdata_o    = alu_res;
        stallreq_o = div_stall;
        whilo_o    = 1'b0;
        hi_o       = '0;
        lo_o       = '0;
        if (div_done) begin
            whilo_o = 1'b1;
            lo_o    = neg_quo_q ? -dend_q : dend_q;
            hi_o    = neg_rem_q ? -rem_q : rem_q;
        end else if (!flush_i && (aluop_i == OP_MTHI)) begin
            whilo_o = 1'b1;
            hi_o    = reg1_i;
            lo_o    = lo_i;
        end else if (!flush_i && (aluop_i == OP_MTLO)) begin
            whilo_o = 1'b1;
            hi_o    = hi_i;
            lo_o    = reg1_i;
        end
        if (!rst) begin
            wd_o       = '0;
            wreg_o     = 1'b0;
            wdata_o    = '0;
            stallreq_o = 1'b0;
            whilo_o    = 1'b0;
            hi_o       = '0;
            lo_o       = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_div.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ex_div
// Description : Self-checking bench for ex_div. Random and directed stimulus
//               compared against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_div;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_MFHI = 8'h10;
    localparam logic [7:0] OP_MTHI = 8'h11;
    localparam logic [7:0] OP_MFLO = 8'h12;
    localparam logic [7:0] OP_MTLO = 8'h13;
    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE  = 3'b011;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i, hi_i, lo_i;
    logic [4:0]  wd_i;
    logic        wreg_i, flush_i;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, stallreq_o;
    logic [31:0] wdata_o, hi_o, lo_o;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    ex_div dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop_i),
        .alusel_i   (alusel_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .hi_i       (hi_i),
        .lo_i       (lo_i),
        .flush_i    (flush_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .whilo_o    (whilo_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .stallreq_o (stallreq_o)
    );

    // Reference: what an instruction means, computed with plain arithmetic
    function automatic void model_alu(input logic [7:0] op, input logic [31:0] a, b, h, l,
                                      output logic [31:0] wdat, output logic wl,
                                      output logic [31:0] eh, output logic [31:0] el);
        int unsigned s;
        logic [31:0] ones;
        s    = a[4:0];
        ones = 32'hFFFF_FFFF;
        wdat = 0; wl = 0; eh = 0; el = 0;
        case (op)
            OP_AND:  wdat = a & b;
            OP_OR:   wdat = a | b;
            OP_XOR:  wdat = a ^ b;
            OP_NOR:  wdat = ~(a | b);
            OP_SLL:  wdat = b << s;
            OP_SRL:  wdat = b >> s;
            OP_SRA:  begin
                wdat = b >> s;
                if (b[31] && s != 0) wdat = wdat | ~(ones >> s);
            end
            OP_MFHI: wdat = h;
            OP_MFLO: wdat = l;
            OP_MTHI: begin wl = 1; eh = a; el = l; end
            OP_MTLO: begin wl = 1; eh = h; el = a; end
            default: wdat = 0;
        endcase
    endfunction

    function automatic logic [2:0] sel_of(input logic [7:0] op);
        case (op)
            OP_SLL, OP_SRL, OP_SRA:            return SEL_SHIFT;
            OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO: return SEL_MOVE;
            default:                            return SEL_LOGIC;
        endcase
    endfunction

    function automatic void model_div(input logic sgn, input logic [31:0] a, b,
                                      output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 0) begin
            q = 0; r = 0;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic test_reset();
        rst = 0; aluop_i = OP_MTHI; alusel_i = SEL_MOVE; reg1_i = 32'hDEAD_BEEF;
        reg2_i = 32'h1234_5678; wd_i = 5'd7; wreg_i = 1; hi_i = 32'h1111_1111;
        lo_i = 32'h2222_2222; flush_i = 0;
        #1;
        compared++; if (wd_o !== 5'd0) begin mismatched++; $display("FAIL reset_wd: got %0d want 0", wd_o); end
        compared++; if (wreg_o !== 1'b0) begin mismatched++; $display("FAIL reset_wreg: got %b want 0", wreg_o); end
        compared++; if (whilo_o !== 1'b0) begin mismatched++; $display("FAIL reset_whilo: got %b want 0", whilo_o); end
        compared++; if (hi_o !== 32'd0) begin mismatched++; $display("FAIL reset_hi: got %h want 0", hi_o); end
        compared++; if (stallreq_o !== 1'b0) begin mismatched++; $display("FAIL reset_stall: got %b want 0", stallreq_o); end
        aluop_i = OP_OR; alusel_i = SEL_LOGIC;
        #1;
        compared++; if (wdata_o !== 32'd0) begin mismatched++; $display("FAIL reset_wdata: got %h want 0", wdata_o); end
        repeat (3) @(negedge clk);
        rst = 1; aluop_i = OP_NOP; alusel_i = SEL_NOP;
    endtask

    task automatic test_logic_directed();
        @(negedge clk);
        aluop_i = OP_OR; alusel_i = SEL_LOGIC; reg1_i = 32'h0000_F0F0; reg2_i = 32'h0000_0F0F;
        wd_i = 5'd5; wreg_i = 1; flush_i = 0;
        #1;
        compared++; if (wdata_o !== 32'h0000_FFFF) begin mismatched++; $display("FAIL or_wdata: got %h want 0000ffff", wdata_o); end
        compared++; if (wd_o !== 5'd5) begin mismatched++; $display("FAIL or_wd: got %0d want 5", wd_o); end
        compared++; if (wreg_o !== 1'b1) begin mismatched++; $display("FAIL or_wreg: got %b want 1", wreg_o); end
        compared++; if (stallreq_o !== 1'b0) begin mismatched++; $display("FAIL or_stall: got %b want 0", stallreq_o); end
        @(negedge clk);
        aluop_i = OP_SRA; alusel_i = SEL_SHIFT; reg1_i = 32'd4; reg2_i = 32'h8000_0010;
        #1;
        compared++; if (wdata_o !== 32'hF800_0001) begin mismatched++; $display("FAIL sra_wdata: got %h want f8000001", wdata_o); end
        @(negedge clk);
        aluop_i = OP_SRL;
        #1;
        compared++; if (wdata_o !== 32'h0800_0001) begin mismatched++; $display("FAIL srl_wdata: got %h want 08000001", wdata_o); end
    endtask

    task automatic test_alu_random();
        logic [7:0]  ops [0:11];
        logic [31:0] ew, eh, el;
        logic        ewl;
        ops = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA,
                OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, 8'hFF};
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            aluop_i  = ops[$urandom_range(0, 11)];
            alusel_i = sel_of(aluop_i);
            reg1_i = $urandom; reg2_i = $urandom; hi_i = $urandom; lo_i = $urandom;
            wd_i = 5'($urandom); wreg_i = 1'($urandom);
            flush_i = ($urandom_range(0, 7) == 0);
            model_alu(aluop_i, reg1_i, reg2_i, hi_i, lo_i, ew, ewl, eh, el);
            if (flush_i) ewl = 0;
            #1;
            compared++; if (wdata_o !== ew) begin mismatched++; $display("FAIL alu_wdata op=%h: got %h want %h", aluop_i, wdata_o, ew); end
            compared++; if (wreg_o !== (wreg_i && !flush_i)) begin mismatched++; $display("FAIL alu_wreg: got %b want %b", wreg_o, wreg_i && !flush_i); end
            compared++; if (wd_o !== wd_i) begin mismatched++; $display("FAIL alu_wd: got %0d want %0d", wd_o, wd_i); end
            compared++; if (whilo_o !== ewl) begin mismatched++; $display("FAIL alu_whilo op=%h: got %b want %b", aluop_i, whilo_o, ewl); end
            compared++; if (stallreq_o !== 1'b0) begin mismatched++; $display("FAIL alu_stall: got %b want 0", stallreq_o); end
            if (ewl) begin
                compared++; if (hi_o !== eh || lo_o !== el) begin mismatched++; $display("FAIL alu_hilo op=%h: got %h/%h want %h/%h", aluop_i, hi_o, lo_o, eh, el); end
            end
        end
        @(negedge clk);
        flush_i = 0; aluop_i = OP_NOP; alusel_i = SEL_NOP;
    endtask

    // One full divide: count stall cycles, check DONE outputs, then IDLE
    task automatic test_divide(input logic [7:0] op, input logic [31:0] a, b);
        int          stalls, want_stalls;
        logic [31:0] eq, er;
        model_div(op == OP_DIV, a, b, eq, er);
        want_stalls = (b == 0) ? 1 : 33;
        @(negedge clk);
        aluop_i = op; alusel_i = SEL_NOP; reg1_i = a; reg2_i = b;
        wd_i = 0; wreg_i = 0; flush_i = 0;
        #1;
        stalls = 0;
        while (stallreq_o === 1'b1 && stalls < 40) begin
            stalls++;
            @(negedge clk);
            reg1_i = $urandom; reg2_i = $urandom;
            #1;
        end
        compared++; if (stalls !== want_stalls) begin mismatched++; $display("FAIL div_stalls %h/%h: got %0d want %0d", a, b, stalls, want_stalls); end
        compared++; if (whilo_o !== 1'b1) begin mismatched++; $display("FAIL div_whilo %h/%h: got %b want 1", a, b, whilo_o); end
        compared++; if (lo_o !== eq) begin mismatched++; $display("FAIL div_quot op=%h %h/%h: got %h want %h", op, a, b, lo_o, eq); end
        compared++; if (hi_o !== er) begin mismatched++; $display("FAIL div_rem op=%h %h/%h: got %h want %h", op, a, b, hi_o, er); end
        compared++; if (wreg_o !== 1'b0) begin mismatched++; $display("FAIL div_wreg: got %b want 0", wreg_o); end
        aluop_i = OP_NOP; reg1_i = 0; reg2_i = 0;
        @(negedge clk);
        #1;
        compared++; if (stallreq_o !== 1'b0 || whilo_o !== 1'b0) begin mismatched++; $display("FAIL div_idle_after: got stall=%b whilo=%b want 0/0", stallreq_o, whilo_o); end
    endtask

    task automatic test_div_directed();
        test_divide(OP_DIVU, 32'd100, 32'd7);
        test_divide(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        test_divide(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        test_divide(OP_DIV, 32'h1234_5678, 32'd0);
        test_divide(OP_DIVU, 32'hFFFF_FFFF, 32'd0);
        test_divide(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        test_divide(OP_DIVU, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    endtask

    task automatic test_div_random();
        logic [7:0]  op;
        logic [31:0] b;
        for (int i = 0; i < 10; i++) begin
            op = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = $urandom_range(1, 20);
                2:       b = -$urandom_range(1, 20);
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            test_divide(op, $urandom, b);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        aluop_i = OP_DIVU; alusel_i = SEL_NOP; reg1_i = 32'd5000; reg2_i = 32'd3;
        wd_i = 0; wreg_i = 1; flush_i = 0;
        repeat (10) @(negedge clk);
        #1;
        compared++; if (stallreq_o !== 1'b1) begin mismatched++; $display("FAIL flush_pre_stall: got %b want 1", stallreq_o); end
        flush_i = 1;
        #1;
        compared++; if (stallreq_o !== 1'b0) begin mismatched++; $display("FAIL flush_stall: got %b want 0", stallreq_o); end
        compared++; if (whilo_o !== 1'b0) begin mismatched++; $display("FAIL flush_whilo: got %b want 0", whilo_o); end
        compared++; if (wreg_o !== 1'b0) begin mismatched++; $display("FAIL flush_wreg: got %b want 0", wreg_o); end
        @(negedge clk);
        flush_i = 0; aluop_i = OP_NOP; wreg_i = 0;
        #1;
        compared++; if (stallreq_o !== 1'b0 || whilo_o !== 1'b0) begin mismatched++; $display("FAIL flush_idle: got stall=%b whilo=%b want 0/0", stallreq_o, whilo_o); end
        test_divide(OP_DIVU, 32'd5000, 32'd3);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        aluop_i = OP_DIVU; alusel_i = SEL_NOP; reg1_i = 32'd999; reg2_i = 32'd10;
        wd_i = 0; wreg_i = 0; flush_i = 0;
        repeat (10) @(negedge clk);
        rst = 0; aluop_i = OP_OR; alusel_i = SEL_LOGIC; reg1_i = 32'h00FF_0000;
        reg2_i = 32'h0000_00FF; wd_i = 5'd9; wreg_i = 1;
        #1;
        compared++; if (stallreq_o !== 1'b0 || whilo_o !== 1'b0) begin mismatched++; $display("FAIL rstrun_ctl: got stall=%b whilo=%b want 0/0", stallreq_o, whilo_o); end
        compared++; if (wdata_o !== 32'd0 || wd_o !== 5'd0 || wreg_o !== 1'b0) begin mismatched++; $display("FAIL rstrun_wb: got %h/%0d/%b want 0/0/0", wdata_o, wd_o, wreg_o); end
        compared++; if (hi_o !== 32'd0 || lo_o !== 32'd0) begin mismatched++; $display("FAIL rstrun_hilo: got %h/%h want 0/0", hi_o, lo_o); end
        @(negedge clk);
        rst = 1; aluop_i = OP_NOP; alusel_i = SEL_NOP; wreg_i = 0;
        #1;
        compared++; if (stallreq_o !== 1'b0) begin mismatched++; $display("FAIL rstrun_idle: got stall=%b want 0", stallreq_o); end
        test_divide(OP_DIVU, $urandom, $urandom_range(1, 1000));
    endtask

    initial begin
        test_reset();
        test_logic_directed();
        test_alu_random();
        test_div_directed();
        test_div_random();
        test_flush();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
